// File: rtl/dma_pkg.sv
// Shared types for the DMA request front end.
// Optional feature macro: DMA_ROTATING_PRIORITY_EN (rotating priority + lastCh).
package dma_pkg;

  localparam int DMA_NUM_CH = 4;

  typedef logic [1:0] ch_idx_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    GRANT = 2'd2
  } arb_state_t;

endpackage

// File: rtl/dma_priority_encoder.sv
// Combinational priority resolver: picks one channel out of pending.
// With DMA_ROTATING_PRIORITY_EN defined, rotatePri=1 starts the search at
// lastCh+1 and walks cyclically; otherwise channel 0 is always highest.
module dma_priority_encoder
  import dma_pkg::*;
(
  input  logic [DMA_NUM_CH-1:0] pending,
  input  ch_idx_t               lastCh,
  input  logic                  rotatePri,
  output ch_idx_t               winner,
  output logic                  anyReq
);

  ch_idx_t base;

`ifdef DMA_ROTATING_PRIORITY_EN
  // Search origin: one past the last serviced channel when rotating.
  always_comb begin
    base = rotatePri ? ch_idx_t'(lastCh + 2'd1) : 2'd0;
  end
`else
  // Fixed priority only; lastCh and rotatePri have no effect.
  logic unused_rot;
  assign unused_rot = ^{lastCh, rotatePri};

  // Search always starts at channel 0.
  always_comb begin
    base = 2'd0;
  end
`endif

  // Walk the channels cyclically from base; first pending one wins.
  always_comb begin
    ch_idx_t idx;
    logic    found;
    winner = 2'd0;
    found  = 1'b0;
    anyReq = |pending;
    for (int i = 0; i < DMA_NUM_CH; i++) begin
      idx = ch_idx_t'(base + ch_idx_t'(i));
      if (!found && pending[idx]) begin
        winner = idx;
        found  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/dma_priority_arbiter.sv
// DMA request front end: registers DREQ, masks it, resolves priority and
// runs the HRQ/HLDA hold handshake before granting one channel to tC.
// Optional feature macro: DMA_ROTATING_PRIORITY_EN.
// Handshake: HRQ is held while a request is pending or granted; a grant is
// issued only on the edge that samples HLDA=1 in REQ, and ends on a
// serviceDone pulse from tC (or on HLDA loss, flagged by holdLost).
// All outputs come straight from flops; next values are computed from the
// next state so output timing matches the state register.
module dma_priority_arbiter
  import dma_pkg::*;
#(
  parameter int NUM_CH = 4
) (
  input  logic              CLK,
  input  logic              RESET_N,
  input  logic [NUM_CH-1:0] DREQ,
  input  logic [NUM_CH-1:0] maskReg,
  input  logic              ctrlDisable,
  input  logic              rotatePri,
  input  logic              HLDA,
  input  logic              serviceDone,
  output logic              HRQ,
  output logic [NUM_CH-1:0] DACK,
  output logic              chValid,
  output logic [1:0]        chSel,
  output logic              holdLost
);

  arb_state_t          state_q, state_d;
  logic [NUM_CH-1:0]   dreq_q;
  ch_idx_t             ch_sel_q, ch_sel_d;
  logic                hrq_q, hrq_d;
  logic [NUM_CH-1:0]   dack_q, dack_d;
  logic                ch_valid_q, ch_valid_d;
  logic                hold_lost_q, hold_lost_d;
  logic [NUM_CH-1:0]   pending;
  ch_idx_t             winner;
  logic                any_req;
  ch_idx_t             last_ch;

  // Masked requests; a disabled controller sees nothing.
  always_comb begin
    pending = ctrlDisable ? '0 : (dreq_q & ~maskReg);
  end

`ifdef DMA_ROTATING_PRIORITY_EN
  ch_idx_t last_ch_q, last_ch_d;

  // Remember the channel that completed service (not one that lost hold).
  always_comb begin
    last_ch_d = last_ch_q;
    if (state_q == GRANT && serviceDone) last_ch_d = ch_sel_q;
  end

  // Last-serviced channel register; resets to 3 so channel 0 leads.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) last_ch_q <= 2'd3;
    else          last_ch_q <= last_ch_d;
  end

  assign last_ch = last_ch_q;
`else
  assign last_ch = 2'd3;
`endif

  dma_priority_encoder u_enc (
    .pending   (pending),
    .lastCh    (last_ch),
    .rotatePri (rotatePri),
    .winner    (winner),
    .anyReq    (any_req)
  );

  // Next state, channel latch and the registered output values.
  always_comb begin
    state_d     = state_q;
    ch_sel_d    = ch_sel_q;
    hold_lost_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (any_req) state_d = REQ;
      end
      REQ: begin
        if (!any_req) begin
          state_d = IDLE;
        end else if (HLDA) begin
          state_d  = GRANT;
          ch_sel_d = winner;
        end
      end
      GRANT: begin
        if (serviceDone) begin
          state_d = IDLE;
        end else if (!HLDA) begin
          state_d     = IDLE;
          hold_lost_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    hrq_d      = (state_d != IDLE);
    ch_valid_d = (state_d == GRANT);
    dack_d     = '0;
    if (state_d == GRANT) dack_d[ch_sel_d] = 1'b1;
  end

  // State, request sampling and output registers.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q     <= IDLE;
      dreq_q      <= '0;
      ch_sel_q    <= 2'd0;
      hrq_q       <= 1'b0;
      dack_q      <= '0;
      ch_valid_q  <= 1'b0;
      hold_lost_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      dreq_q      <= DREQ;
      ch_sel_q    <= ch_sel_d;
      hrq_q       <= hrq_d;
      dack_q      <= dack_d;
      ch_valid_q  <= ch_valid_d;
      hold_lost_q <= hold_lost_d;
    end
  end

  assign HRQ      = hrq_q;
  assign DACK     = dack_q;
  assign chValid  = ch_valid_q;
  assign chSel    = ch_sel_q;
  assign holdLost = hold_lost_q;

endmodule

// File: tb/tb_dma_priority_arbiter.sv
// Directed bench for dma_priority_arbiter. Inputs change 1ns after a rising
// edge; outputs are checked at the same point, i.e. after each edge settles.
module tb_dma_priority_arbiter;

  logic       CLK;
  logic       RESET_N;
  logic [3:0] DREQ;
  logic [3:0] maskReg;
  logic       ctrlDisable;
  logic       rotatePri;
  logic       HLDA;
  logic       serviceDone;
  logic       HRQ;
  logic [3:0] DACK;
  logic       chValid;
  logic [1:0] chSel;
  logic       holdLost;

  int total = 0;
  int bad   = 0;

  dma_priority_arbiter #(.NUM_CH(4)) dut (
    .CLK         (CLK),
    .RESET_N     (RESET_N),
    .DREQ        (DREQ),
    .maskReg     (maskReg),
    .ctrlDisable (ctrlDisable),
    .rotatePri   (rotatePri),
    .HLDA        (HLDA),
    .serviceDone (serviceDone),
    .HRQ         (HRQ),
    .DACK        (DACK),
    .chValid     (chValid),
    .chSel       (chSel),
    .holdLost    (holdLost)
  );

  // Clock
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Advance one edge and settle.
  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // Bounded wait for HRQ to rise.
  task automatic wait_hrq(input string tag);
    for (int i = 0; i < 10 && HRQ !== 1'b1; i++) step();
    chk(tag, {3'b0, HRQ}, 4'b0001);
  endtask

  // Return HLDA, check the grant, then finish the service with serviceDone.
  task automatic serve(input string tag, input logic [3:0] exp_dack);
    HLDA = 1'b1;
    step();
    chk({tag, "_dack"}, DACK, exp_dack);
    serviceDone = 1'b1;
    step();
    serviceDone = 1'b0;
    HLDA        = 1'b0;
    chk({tag, "_done"}, DACK, 4'b0000);
  endtask

  task automatic go_idle();
    DREQ = 4'b0000; HLDA = 1'b0; serviceDone = 1'b0;
    repeat (3) step();
  endtask

  initial begin
    RESET_N = 1'b0; DREQ = 4'b1111; maskReg = 4'b0000; ctrlDisable = 1'b0;
    rotatePri = 1'b0; HLDA = 1'b1; serviceDone = 1'b0;

    // Reset with requests and HLDA asserted
    repeat (3) step();
    chk("rst_hrq", {3'b0, HRQ}, 4'b0000);
    chk("rst_dack", DACK, 4'b0000);
    chk("rst_chsel", {2'b0, chSel}, 4'b0000);
    chk("rst_chvalid", {3'b0, chValid}, 4'b0000);
    chk("rst_holdlost", {3'b0, holdLost}, 4'b0000);
    RESET_N = 1'b1; HLDA = 1'b0;
    step();
    chk("rel_hrq_edge1", {3'b0, HRQ}, 4'b0000);
    step();
    chk("rel_hrq_edge2", {3'b0, HRQ}, 4'b0001);
    serve("rst_serve", 4'b0001);
    DREQ = 4'b0000;
    step();
    chk("rereq_hrq", {3'b0, HRQ}, 4'b0001);
    go_idle();
    chk("idle_hrq", {3'b0, HRQ}, 4'b0000);

    // Single request, HLDA returned three cycles after HRQ
    DREQ = 4'b0001;
    wait_hrq("single_hrq");
    repeat (3) step();
    chk("single_wait_dack", DACK, 4'b0000);
    HLDA = 1'b1;
    step();
    chk("single_dack", DACK, 4'b0001);
    chk("single_chsel", {2'b0, chSel}, 4'b0000);
    chk("single_chvalid", {3'b0, chValid}, 4'b0001);
    serviceDone = 1'b1;
    step();
    serviceDone = 1'b0; HLDA = 1'b0; DREQ = 4'b0000;
    chk("single_done_dack", DACK, 4'b0000);
    chk("single_done_hrq", {3'b0, HRQ}, 4'b0000);
    chk("single_done_chvalid", {3'b0, chValid}, 4'b0000);
    go_idle();

    // Fixed priority, twice
    rotatePri = 1'b0;
    DREQ = 4'b1010;
    wait_hrq("fix1_hrq");
    serve("fix1", 4'b0010);
    chk("fix1_chsel", {2'b0, chSel}, 4'b0001);
    go_idle();
    DREQ = 4'b1010;
    wait_hrq("fix2_hrq");
    serve("fix2", 4'b0010);
    go_idle();

`ifdef DMA_ROTATING_PRIORITY_EN
    // Rotating priority from a fresh reset (lastCh = 3)
    RESET_N = 1'b0;
    step();
    RESET_N = 1'b1;
    rotatePri = 1'b1;
    DREQ = 4'b1111;
    wait_hrq("rot_hrq0");
    serve("rot0", 4'b0001);
    wait_hrq("rot_hrq1");
    serve("rot1", 4'b0010);
    wait_hrq("rot_hrq2");
    serve("rot2", 4'b0100);
    wait_hrq("rot_hrq3");
    serve("rot3", 4'b1000);
    wait_hrq("rot_hrq4");
    serve("rot4", 4'b0001);
    rotatePri = 1'b0;
    go_idle();
`endif

    // Masked request never raises HRQ
    maskReg = 4'b0001; DREQ = 4'b0001;
    repeat (4) step();
    chk("mask_hrq", {3'b0, HRQ}, 4'b0000);
    // Controller disable blocks requests too
    maskReg = 4'b0000; ctrlDisable = 1'b1; DREQ = 4'b0100;
    repeat (4) step();
    chk("disable_hrq", {3'b0, HRQ}, 4'b0000);
    ctrlDisable = 1'b0;
    // Withdrawal in REQ before HLDA
    DREQ = 4'b0001;
    wait_hrq("wd_hrq");
    DREQ = 4'b0000;
    repeat (2) step();
    chk("wd_hrq_fall", {3'b0, HRQ}, 4'b0000);
    chk("wd_dack", DACK, 4'b0000);
    go_idle();

    // Hold loss on channel 2
    DREQ = 4'b0100;
    wait_hrq("hl_hrq");
    HLDA = 1'b1;
    step();
    chk("hl_dack", DACK, 4'b0100);
    chk("hl_chsel", {2'b0, chSel}, 4'b0010);
    // Request changes do not preempt the grant
    DREQ = 4'b0001; maskReg = 4'b1111;
    repeat (2) step();
    chk("nopreempt_dack", DACK, 4'b0100);
    maskReg = 4'b0000; DREQ = 4'b0100;
    HLDA = 1'b0;
    step();
    chk("hl_pulse", {3'b0, holdLost}, 4'b0001);
    chk("hl_pulse_dack", DACK, 4'b0000);
    chk("hl_pulse_hrq", {3'b0, HRQ}, 4'b0000);
    step();
    chk("hl_pulse_end", {3'b0, holdLost}, 4'b0000);
    // serviceDone and HLDA drop together: no pulse
    wait_hrq("hl2_hrq");
    HLDA = 1'b1;
    step();
    chk("hl2_dack", DACK, 4'b0100);
    serviceDone = 1'b1; HLDA = 1'b0;
    step();
    serviceDone = 1'b0;
    chk("hl2_nopulse", {3'b0, holdLost}, 4'b0000);
    chk("hl2_dack_off", DACK, 4'b0000);
    step();
    chk("hl2_nopulse_late", {3'b0, holdLost}, 4'b0000);

    // Reset mid-grant clears outputs at once
    wait_hrq("mr_hrq");
    HLDA = 1'b1;
    step();
    chk("mr_dack", DACK, 4'b0100);
    RESET_N = 1'b0;
    #1;
    chk("mr_dack_clr", DACK, 4'b0000);
    chk("mr_hrq_clr", {3'b0, HRQ}, 4'b0000);
    chk("mr_chvalid_clr", {3'b0, chValid}, 4'b0000);
    step();
    chk("mr_holdlost", {3'b0, holdLost}, 4'b0000);
    RESET_N = 1'b1;
    go_idle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
